// File: rtl/calc_hist.sv
// calc_hist: debounced accumulator calculator with signed ALU, flags and undo history
module calc_hist #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int DB_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       btnu,
  input  logic                       btnd,
  input  logic                       btn_undo,
  input  logic                       btnl,
  input  logic                       btnc,
  input  logic                       btnr,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       ovf,
  output logic                       zero,
  output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);
  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW  = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam int HW  = $clog2(DEPTH + 1);
  logic [4:0]       s1, s2;
  logic [1:0]       deb, deb_q;
  logic             upd, und, rovf;
  logic [2:0]       op;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [PW-1:0]    wp, nxt, prv;
  // s1/s2 bits: {btnd, btn_undo, btnl, btnc, btnr}
  always_ff @(posedge clk or posedge btnu)
    if (btnu) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btnd, btn_undo, btnl, btnc, btnr};
      s2 <= s1;
    end
  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_db
      if (DB_CYCLES == 0) begin : g_none
        assign deb[i] = s2[3+i];
      end else begin : g_cnt
        logic [CW-1:0] cnt;
        logic          lvl;
        always_ff @(posedge clk or posedge btnu)
          if (btnu) begin
            cnt <= '0;
            lvl <= 1'b0;
          end else if (s2[3+i] == lvl) begin
            cnt <= '0;
          end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt <= '0;
            lvl <= ~lvl;
          end else begin
            cnt <= cnt + 1'b1;
          end
        assign deb[i] = lvl;
      end
    end
  endgenerate
  assign upd  = deb[1] & ~deb_q[1];
  assign und  = deb[0] & ~deb_q[0];
  assign op   = s2[2:0];
  assign sh   = sw[SHW-1:0];
  assign nxt  = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
  assign prv  = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;
  assign zero = (led == '0);
  always_comb begin
    res  = '0;
    rovf = 1'b0;
    case (op)
      3'd0: begin
        res  = led + sw;
        rovf = (led[WIDTH-1] == sw[WIDTH-1]) && (res[WIDTH-1] != led[WIDTH-1]);
      end
      3'd1: begin
        res  = led - sw;
        rovf = (led[WIDTH-1] != sw[WIDTH-1]) && (res[WIDTH-1] != led[WIDTH-1]);
      end
      3'd2: res = led & sw;
      3'd3: res = led | sw;
      3'd4: res = led ^ sw;
      3'd5: res = {{(WIDTH-1){1'b0}}, $signed(led) < $signed(sw)};
      3'd6: res = led << sh;
      3'd7: res = $signed(led) >>> sh;
    endcase
  end
  // undo has priority; the update is dropped when both pulse together
  always_ff @(posedge clk or posedge btnu)
    if (btnu) begin
      led      <= '0;
      ovf      <= 1'b0;
      hist_cnt <= '0;
      wp       <= '0;
      deb_q    <= '0;
    end else begin
      deb_q <= deb;
      if (und) begin
        if (hist_cnt != '0) begin
          led      <= hist[prv];
          wp       <= prv;
          hist_cnt <= hist_cnt - 1'b1;
          ovf      <= 1'b0;
        end
      end else if (upd) begin
        led <= res;
        ovf <= rovf;
        wp  <= nxt;
        if (hist_cnt != HW'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (upd && !und) hist[wp] <= led;
endmodule

// File: tb/tb_calc_hist.sv
// tb_calc_hist: directed stimulus with a queue-based reference model checked every cycle
module tb_calc_hist;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DB = 4;
  logic         clk = 1'b0, btnu = 1'b1, btnd = 1'b0, btn_undo = 1'b0;
  logic         btnl = 1'b0, btnc = 1'b0, btnr = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] led;
  logic         ovf, zero;
  logic [2:0]   hist_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0, rst_cyc = 0;
  int due_upd = -1, due_und = -1;
  int m_acc = 0;
  bit m_ovf = 1'b0;
  int hq[$];

  calc_hist #(.WIDTH(W), .DEPTH(D), .DB_CYCLES(DB)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .btn_undo(btn_undo),
    .btnl(btnl), .btnc(btnc), .btnr(btnr), .sw(sw),
    .led(led), .ovf(ovf), .zero(zero), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return v >= 32768 ? v - 65536 : v;
  endfunction

  task automatic apply_op();
    int a = m_acc;
    int b = int'(sw);
    int sa = sx(a);
    int sb = sx(b);
    int sh = b % 16;
    int r = 0;
    bit o = 1'b0;
    case ({btnl, btnc, btnr})
      3'd0: begin r = sa + sb; o = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; o = (r > 32767) || (r < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = a << sh;
      3'd7: r = sa >>> sh;
    endcase
    hq.push_back(a);
    if (hq.size() > D) hq.delete(0);
    m_acc = r & 32'hFFFF;
    m_ovf = o;
  endtask

  // model: actions land 3+DB edges after the first edge that sees the press
  always @(posedge clk) begin
    cyc++;
    if (btnu) begin
      m_acc = 0;
      m_ovf = 1'b0;
      hq.delete();
      rst_cyc = cyc;
    end else if (cyc == due_und && due_und - 3 - DB >= rst_cyc) begin
      if (hq.size() > 0) begin
        m_acc = hq.pop_back();
        m_ovf = 1'b0;
      end
    end else if (cyc == due_upd && due_upd - 3 - DB >= rst_cyc) begin
      apply_op();
    end
  end

  always @(posedge clk) begin
    #1;
    chk("led", led, m_acc);
    chk("ovf", ovf, m_ovf);
    chk("zero", zero, m_acc == 0);
    chk("hist_cnt", hist_cnt, hq.size());
  end

  task automatic press(input bit u, input bit d, input int hold);
    @(negedge clk);
    btnd = d;
    btn_undo = u;
    if (hold >= DB) begin
      if (d) due_upd = cyc + 3 + DB;
      if (u) due_und = cyc + 3 + DB;
    end
    repeat (hold) @(negedge clk);
    btnd = 1'b0;
    btn_undo = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic setop(input logic [2:0] op, input logic [W-1:0] v);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    btnu = 1'b1;
    repeat (2) @(negedge clk);
    btnu = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    btnu = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_led", led, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    chk("rst_hist", hist_cnt, 0);
    setop(3'd0, 16'h1234);
    @(negedge clk);
    btnd = 1'b1;
    due_upd = cyc + 3 + DB;
    repeat (6) @(posedge clk);
    #1;
    chk("edge6_led", led, 16'h0000);
    @(posedge clk);
    #1;
    chk("edge7_led", led, 16'h1234);
    repeat (14) @(negedge clk);
    btnd = 1'b0;
    repeat (14) @(negedge clk);
    chk("held_led", led, 16'h1234);
    chk("held_hist", hist_cnt, 1);
    chk("held_zero", zero, 0);
    setop(3'd0, 16'h7346);
    press(1'b0, 1'b1, 8);
    chk("add_ovf_led", led, 16'h857A);
    chk("add_ovf", ovf, 1);
    setop(3'd1, 16'h857A);
    press(1'b0, 1'b1, 8);
    chk("sub_led", led, 16'h0000);
    chk("sub_zero", zero, 1);
    chk("sub_ovf", ovf, 0);
    setop(3'd0, 16'h0005);
    press(1'b0, 1'b1, 3);
    chk("glitch_led", led, 16'h0000);
    chk("glitch_hist", hist_cnt, 3);
    @(negedge clk);
    btnd = 1'b1;
    due_upd = cyc + 3 + DB;
    repeat (3) @(negedge clk);
    btnu = 1'b1;
    repeat (2) @(negedge clk);
    btnd = 1'b0;
    btnu = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_led", led, 0);
    chk("midrst_hist", hist_cnt, 0);
    chk("midrst_ovf", ovf, 0);
    do_reset();
    setop(3'd0, 16'h0001);
    repeat (5) press(1'b0, 1'b1, 8);
    chk("five_led", led, 5);
    chk("five_hist", hist_cnt, 4);
    for (int k = 4; k >= 1; k--) begin
      press(1'b1, 1'b0, 8);
      chk("undo_led", led, k);
    end
    chk("undo_hist", hist_cnt, 0);
    press(1'b1, 1'b0, 8);
    chk("undo_empty_led", led, 1);
    press(1'b0, 1'b1, 8);
    chk("pre_both_led", led, 2);
    press(1'b1, 1'b1, 8);
    chk("both_led", led, 1);
    chk("both_hist", hist_cnt, 0);
    do_reset();
    setop(3'd0, 16'h8000);
    press(1'b0, 1'b1, 8);
    setop(3'd7, 16'h0004);
    press(1'b0, 1'b1, 8);
    chk("sra_led", led, 16'hF800);
    do_reset();
    setop(3'd0, 16'hFFFF);
    press(1'b0, 1'b1, 8);
    setop(3'd5, 16'h0001);
    press(1'b0, 1'b1, 8);
    chk("slt_led", led, 16'h0001);
    setop(3'd6, 16'h000F);
    press(1'b0, 1'b1, 8);
    chk("sll_led", led, 16'h8000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_hist.md
Name: calc_hist

Overview:
Parametrised accumulator calculator, the successor of the 16-bit board calculator.
- WIDTH-bit accumulator driven by an ALU: operand A = accumulator, operand B = sw, op selected by {btnl,btnc,btnr}.
- Adds input synchronisation and debouncing, single-shot update on press, signed-overflow and zero flags, and a DEPTH-entry undo history.
- Top-level block for FPGA board bring-up: switches/buttons in, LEDs out.

Parameters:
WIDTH, 16, accumulator/switch/LED width (>=4)
DEPTH, 8, undo history entries (>=1)
DB_CYCLES, 500000, cycles a synchronised button must hold a new level before it is accepted (0 = no debounce)

Ports:
clk  in  1  system clock, rising edge
btnu  in  1  reset, asynchronous, active-high
btnd  in  1  update button: apply ALU op to accumulator
btn_undo  in  1  undo button: restore previous accumulator value
btnl  in  1  op bit 2
btnc  in  1  op bit 1
btnr  in  1  op bit 0
sw  in  WIDTH  operand B
led  out  WIDTH  accumulator value
ovf  out  1  signed overflow of last applied op
zero  out  1  high when accumulator == 0
hist_cnt  out  $clog2(DEPTH+1)  valid history entries

Behaviour:
- Reset (btnu=1, any time including mid-debounce or mid-operation):
  - acc=0, led=0, ovf=0, hist_cnt=0.
  - History pointers, synchronisers, debounce counters and debounced levels all cleared.
  - zero=1.
- Input path:
  - btnd, btn_undo, btnl, btnc and btnr each pass through a 2-flop synchroniser.
  - sw is used unsynchronised (quasi-static).
- Debounce (btnd, btn_undo only):
  - Counter increments while the synchronised level differs from the debounced level; it clears when they match.
  - When the counter reaches DB_CYCLES, the debounced level toggles and the counter clears.
  - Pulses shorter than DB_CYCLES cycles are ignored.
- Edge detect: one-cycle pulse on the debounced rising edge only. A held button produces exactly one action; release produces none.
- Latency: take edge 1 as the first clk edge sampling the raw button high. The debounced level rises at edge 2+DB_CYCLES and the acc/led update at edge 3+DB_CYCLES.
- Op is the synchronised {btnl,btnc,btnr}, sampled in the pulse cycle:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT signed (result 1 or 0, zero-extended)
  - 110 SLL by sw[$clog2(WIDTH)-1:0]
  - 111 SRA by sw[$clog2(WIDTH)-1:0]
- Arithmetic: all results are WIDTH bits, wrap-around, two's complement.
- ovf:
  - ADD/SUB: ovf=1 on signed overflow, otherwise 0.
  - All other ops: ovf=0.
  - ovf is registered alongside acc.
- Update pulse:
  - Push old acc into the circular history buffer, then acc <= ALU result.
  - hist_cnt increments, saturating at DEPTH; when full, the oldest entry is overwritten.
- Undo pulse:
  - If hist_cnt>0: acc <= newest entry, pop it, hist_cnt decrements, ovf <= 0.
  - If hist_cnt==0: no change.
- Both pulses in the same cycle: undo wins, update is discarded.
- led = acc (registered).
- zero is combinational from acc.

Test Plan:
(WIDTH=16, DEPTH=4, DB_CYCLES=4)
1. btnu=1 for 2 cycles, release -> led=0x0000, ovf=0, zero=1, hist_cnt=0.
2. Op=000, sw=0x1234, btnd held 20 cycles -> led=0x1234 exactly at edge 7; a single update only; hist_cnt=1, zero=0.
3. From 0x1234: op=000, sw=0x7346 -> led=0x857A, ovf=1. Then op=001, sw=0x857A -> led=0x0000, zero=1, ovf=0.
4. btnd high 3 cycles then low (glitch) -> led and hist_cnt unchanged. Assert btnu during a valid press's debounce window -> all outputs 0, no update after release of reset.
5. Five ADD updates with sw=1 from 0 (values 1..5) -> hist_cnt=4. Four undos -> led steps 4,3,2,1, hist_cnt=0. Fifth undo -> led=1 unchanged. btnd and btn_undo pulsing together -> undo-only result.
6. acc=0x8000, op=111, sw=0x0004 -> led=0xF800. acc=0xFFFF, op=101, sw=0x0001 -> led=0x0001. acc=0x0001, op=110, sw=0x000F -> led=0x8000.
